// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - SPI command FIFO and guard-time scheduler; SPI_SEQ_IRQ_EN enables the drained irq
module spi_cmd_sequencer #(
   parameter int DEPTH    = 16,
   parameter int AW       = 4,
   parameter int XFER_GAP = 460,
   parameter int PWR_GAP  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [9:0]  wr_data,
   input  logic        flush,
   output logic [31:0] status,
   output logic        spi_start,
   output logic [9:0]  spi_din,
   output logic        irq
);

   localparam int GMAX = (XFER_GAP > PWR_GAP) ? XFER_GAP : PWR_GAP;
   localparam int GW   = $clog2(GMAX + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t          state, state_nxt;
   logic [9:0]      mem [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [AW:0]     count;
   logic            ovf;
   logic [GW-1:0]   gap_cnt;
   logic            full, empty, busy, push, pop, gap_done;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign busy     = (state != IDLE);
   assign push     = wr_en && !flush && !full;
   assign gap_done = (gap_cnt <= GW'(1));
   assign status   = {20'h0, ovf, busy, full, empty, 8'(count)};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // The pop happens on the edge entering ISSUE so spi_start is visible during ISSUE.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !flush) begin
               state_nxt = ISSUE;
               pop       = 1'b1;
            end
         end
         ISSUE: state_nxt = HOLD;
         HOLD: begin
            if (gap_done) begin
               if (!empty && !flush) begin
                  state_nxt = ISSUE;
                  pop       = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // A write while full is dropped even when a pop frees a slot in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         if (wr_en && full) ovf <= 1'b1;
      end
   end

   // ISSUE plus the HOLD cycles together span exactly the guard time of the word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spi_start <= 1'b0;
         spi_din   <= '0;
         gap_cnt   <= '0;
      end else begin
         spi_start <= pop;
         if (pop) spi_din <= mem[rd_ptr];
         if (state == ISSUE)
            gap_cnt <= spi_din[9] ? GW'(PWR_GAP - 1) : GW'(XFER_GAP - 1);
         else if (state == HOLD && gap_cnt != '0)
            gap_cnt <= gap_cnt - GW'(1);
      end
   end

`ifdef SPI_SEQ_IRQ_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) irq <= 1'b0;
      else       irq <= (state == HOLD) && (state_nxt == IDLE);
   end
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - self-checking bench for spi_cmd_sequencer against a queue/timer model
module tb_spi_cmd_sequencer;

   localparam int DEPTH = 16;
   localparam int XFER  = 460;
   localparam int PWR   = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [9:0]  wr_data = '0;
   logic        flush = 1'b0;
   logic [31:0] status;
   logic        spi_start;
   logic [9:0]  spi_din;
   logic        irq;

   int checks = 0;
   int errors = 0;

   int         q[$];
   bit         m_ovf;
   int         busy_left;
   bit         m_start;
   logic [9:0] m_din;
   bit         m_irq;

   spi_cmd_sequencer #(.DEPTH(DEPTH), .AW(4), .XFER_GAP(XFER), .PWR_GAP(PWR)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
      .status(status), .spi_start(spi_start), .spi_din(spi_din), .irq(irq)
   );

   always #8 clk = ~clk;

   function automatic logic [31:0] exp_status();
      int sz = q.size();
      return {20'h0, m_ovf, busy_left > 0, sz == DEPTH, sz == 0, 8'(sz)};
   endfunction

   function automatic logic exp_irq();
`ifdef SPI_SEQ_IRQ_EN
      return m_irq;
`else
      return 1'b0;
`endif
   endfunction

   // Model: a word may be issued once the previous guard time has at most one cycle left.
   task automatic tick();
      int sz0;
      bit iss;
      @(posedge clk);
      if (reset) begin
         q.delete(); m_ovf = 0; busy_left = 0; m_start = 0; m_din = '0; m_irq = 0;
      end else begin
         sz0 = q.size();
         iss = (busy_left <= 1) && (sz0 > 0) && !flush;
         m_irq = (busy_left == 1) && !iss;
         if (iss) begin
            m_din = 10'(q.pop_front());
            busy_left = m_din[9] ? PWR : XFER;
         end else if (busy_left > 0) begin
            busy_left--;
         end
         m_start = iss;
         if (flush) begin
            q.delete(); m_ovf = 0;
         end else if (wr_en) begin
            if (sz0 == DEPTH) m_ovf = 1;
            else q.push_back(int'(wr_data));
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++; if (status !== 32'h0000_0100) begin errors++; $display("FAIL reset_status got %h exp %h", status, 32'h100); end
      checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", spi_start); end
      checks++; if (spi_din !== 10'h0) begin errors++; $display("FAIL reset_din got %h exp 0", spi_din); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
      reset = 1'b0;
      repeat (5) begin
         tick();
         checks++; if (status !== 32'h0000_0100 || spi_start !== 1'b0) begin errors++; $display("FAIL idle got status=%h start=%b exp 100/0", status, spi_start); end
      end
   endtask

   task automatic test_single();
      int starts = 0, busy_cycles = 0;
      wr_en = 1'b1; wr_data = 10'h0A5;
      tick();
      wr_en = 1'b0;
      tick();
      checks++; if (spi_start !== 1'b1 || spi_din !== 10'h0A5) begin errors++; $display("FAIL single_latency got start=%b din=%h exp 1/0a5", spi_start, spi_din); end
      if (status[10]) busy_cycles++;
      if (spi_start) starts++;
      repeat (470) begin
         tick();
         if (status[10]) busy_cycles++;
         if (spi_start) starts++;
         checks++;
         if ({spi_start, spi_din, irq, status} !== {m_start, m_din, exp_irq(), exp_status()}) begin
            errors++; $display("FAIL single_cycle got start=%b din=%h irq=%b status=%h exp %b %h %b %h", spi_start, spi_din, irq, status, m_start, m_din, exp_irq(), exp_status());
         end
      end
      checks++; if (busy_cycles !== XFER) begin errors++; $display("FAIL single_busy got %0d exp %0d", busy_cycles, XFER); end
      checks++; if (starts !== 1) begin errors++; $display("FAIL single_starts got %0d exp 1", starts); end
      checks++; if (status !== 32'h0000_0100) begin errors++; $display("FAIL single_end got %h exp 100", status); end
   endtask

   task automatic test_back_to_back();
      int cyc = 0, first = -1, second = -1, irqs = 0, exp_irqs;
      wr_en = 1'b1; wr_data = 10'h200;
      tick();
      wr_data = 10'h1C3;
      tick(); cyc++;
      if (spi_start) first = cyc;
      wr_en = 1'b0;
      repeat (480) begin
         tick(); cyc++;
         if (spi_start) begin if (first < 0) first = cyc; else second = cyc; end
         if (irq) irqs++;
         checks++;
         if ({spi_start, spi_din, irq, status} !== {m_start, m_din, exp_irq(), exp_status()}) begin
            errors++; $display("FAIL b2b_cycle got start=%b din=%h irq=%b status=%h exp %b %h %b %h", spi_start, spi_din, irq, status, m_start, m_din, exp_irq(), exp_status());
         end
      end
      checks++; if (second - first !== PWR) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", second - first, PWR); end
`ifdef SPI_SEQ_IRQ_EN
      exp_irqs = 1;
`else
      exp_irqs = 0;
`endif
      checks++; if (irqs !== exp_irqs) begin errors++; $display("FAIL b2b_irq_count got %0d exp %0d", irqs, exp_irqs); end
   endtask

   task automatic test_overflow();
      logic [9:0] w;
      logic [9:0] dropped;
      int starts = 1, leaks = 0;
      wr_en = 1'b1; wr_data = 10'h0A5;
      tick();
      wr_en = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < 17; i++) begin
         w = 10'($urandom_range(0, 1023));
         w[8] = (i == 16);
         if (i == 16) dropped = w;
         wr_en = 1'b1; wr_data = w;
         tick();
      end
      wr_en = 1'b0;
      tick();
      checks++; if (status !== 32'h0000_0E10) begin errors++; $display("FAIL ovf_full got %h exp e10", status); end
      repeat (17 * XFER + 20) begin
         tick();
         if (spi_start) starts++;
         if (spi_start && spi_din === dropped) leaks++;
         checks++;
         if ({spi_start, spi_din, irq, status} !== {m_start, m_din, exp_irq(), exp_status()}) begin
            errors++; $display("FAIL ovf_cycle got start=%b din=%h irq=%b status=%h exp %b %h %b %h", spi_start, spi_din, irq, status, m_start, m_din, exp_irq(), exp_status());
         end
      end
      checks++; if (starts !== 17) begin errors++; $display("FAIL ovf_starts got %0d exp 17", starts); end
      checks++; if (leaks !== 0) begin errors++; $display("FAIL ovf_dropped_seen got %0d exp 0", leaks); end
   endtask

   task automatic test_flush();
      int starts = 0;
      wr_en = 1'b1; wr_data = 10'h055;
      tick();
      wr_en = 1'b0;
      repeat (2) tick();
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 10'($urandom_range(0, 1023));
         tick();
      end
      wr_en = 1'b1; flush = 1'b1; wr_data = 10'h3FF;
      tick();
      wr_en = 1'b0; flush = 1'b0;
      checks++; if (status !== 32'h0000_0500) begin errors++; $display("FAIL flush_clear got %h exp 500", status); end
      repeat (470) begin
         tick();
         if (spi_start) starts++;
         checks++;
         if ({spi_start, spi_din, irq, status} !== {m_start, m_din, exp_irq(), exp_status()}) begin
            errors++; $display("FAIL flush_cycle got start=%b din=%h irq=%b status=%h exp %b %h %b %h", spi_start, spi_din, irq, status, m_start, m_din, exp_irq(), exp_status());
         end
      end
      checks++; if (starts !== 0) begin errors++; $display("FAIL flush_starts got %0d exp 0", starts); end
   endtask

   task automatic test_random();
      logic [9:0] w;
      repeat (3000) begin
         w = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0) w[9] = 1'b1;
         wr_en   = ($urandom_range(0, 39) == 0);
         wr_data = w;
         flush   = ($urandom_range(0, 499) == 0);
         tick();
         checks++;
         if ({spi_start, spi_din, irq, status} !== {m_start, m_din, exp_irq(), exp_status()}) begin
            errors++; $display("FAIL rand_cycle got start=%b din=%h irq=%b status=%h exp %b %h %b %h", spi_start, spi_din, irq, status, m_start, m_din, exp_irq(), exp_status());
         end
      end
      wr_en = 1'b0; flush = 1'b0;
      repeat (470) tick();
   endtask

   task automatic test_reset_mid();
      int starts = 0;
      wr_en = 1'b1; wr_data = 10'h0C0;
      tick();
      wr_en = 1'b0;
      repeat (2) tick();
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_data = 10'($urandom_range(0, 1023));
         tick();
      end
      wr_en = 1'b0;
      repeat (10) tick();
      #3 reset = 1'b1;
      #1;
      checks++; if ({spi_start, spi_din, irq, status} !== {1'b0, 10'h0, 1'b0, 32'h0000_0100}) begin
         errors++; $display("FAIL async_reset got start=%b din=%h irq=%b status=%h exp 0 000 0 00000100", spi_start, spi_din, irq, status);
      end
      tick();
      reset = 1'b0;
      repeat (30) begin
         tick();
         if (spi_start) starts++;
         checks++;
         if ({spi_start, spi_din, irq, status} !== {m_start, m_din, exp_irq(), exp_status()}) begin
            errors++; $display("FAIL post_reset_cycle got start=%b din=%h irq=%b status=%h exp %b %h %b %h", spi_start, spi_din, irq, status, m_start, m_din, exp_irq(), exp_status());
         end
      end
      checks++; if (starts !== 0) begin errors++; $display("FAIL post_reset_starts got %0d exp 0", starts); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_flush();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
